// File: rtl/pb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pb_pkg                                                |
// | Brief    : Shared state encoding and defaults for push-button    |
// |            conditioning (pb_sync, pb_debounce).                  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package pb_pkg;

    typedef logic [1:0] pb_state_t;

    localparam pb_state_t c_IDLE         = 2'd0;
    localparam pb_state_t c_PRESS_WAIT   = 2'd1;
    localparam pb_state_t c_PRESSED      = 2'd2;
    localparam pb_state_t c_RELEASE_WAIT = 2'd3;

    // 20 ms at 50 MHz
    localparam int PB_DEBOUNCE_DEFAULT = 1000000;

endpackage : pb_pkg
`default_nettype wire

// File: rtl/pb_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pb_sync                                               |
// | Brief    : SYNC_STAGES-deep flop chain bringing an asynchronous  |
// |            pad into clk; synchronous reset to 0.                 |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module pb_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule : pb_sync
`default_nettype wire

// File: rtl/pb_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pb_debounce                                           |
// | Brief    : Push-button synchroniser + stable-time filter with    |
// |            clean level and one-cycle press/release strobes.      |
// |            Define PB_ACTIVE_LOW_EN for pull-up buttons           |
// |            (pad 0 = pressed).                                    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module pb_debounce
    import pb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_raw,
    output logic pb_level,
    output logic pb_press,
    output logic pb_release
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               w_pb_logical;
    logic               w_s;
    pb_state_t          r_state;
    pb_state_t          w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_level;
    logic               r_press;
    logic               r_release;
    logic               w_level_nxt;
    logic               w_press_nxt;
    logic               w_release_nxt;

`ifdef PB_ACTIVE_LOW_EN
    assign w_pb_logical = ~pb_raw;
`else
    assign w_pb_logical = pb_raw;
`endif

    pb_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (w_pb_logical),
        .o_sync  (w_s)
    );

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Any opposite-level sample drops the candidate; cnt stops at the last value.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = c_PRESSED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = c_PRESS_WAIT;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
            end
            c_PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_PRESSED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            c_PRESSED: begin
                if (!w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = c_RELEASE_WAIT;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
            end
            c_RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_nxt = c_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Strobes come only from an accepted change, never from a rejected bounce.
    always_comb begin
        w_level_nxt   = (w_state_nxt == c_PRESSED) || (w_state_nxt == c_RELEASE_WAIT);
        w_press_nxt   = (w_state_nxt == c_PRESSED) &&
                        ((r_state == c_IDLE) || (r_state == c_PRESS_WAIT));
        w_release_nxt = (w_state_nxt == c_IDLE) &&
                        ((r_state == c_PRESSED) || (r_state == c_RELEASE_WAIT));
    end

    assign pb_level   = r_level;
    assign pb_press   = r_press;
    assign pb_release = r_release;

endmodule : pb_debounce
`default_nettype wire

// File: tb/tb_pb_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_pb_debounce                                        |
// | Brief    : Directed self-checking bench for pb_debounce          |
// |            (DEBOUNCE_CYCLES=8, SYNC_STAGES=2; PB_ACTIVE_LOW_EN   |
// |            selects pad polarity).                                |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_pb_debounce;

    logic clk;
    logic rst;
    logic pb_raw;
    logic pb_level;
    logic pb_press;
    logic pb_release;

    int total = 0;
    int bad   = 0;

    pb_debounce #(
        .DEBOUNCE_CYCLES (8),
        .SYNC_STAGES     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pb_raw     (pb_raw),
        .pb_level   (pb_level),
        .pb_press   (pb_press),
        .pb_release (pb_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logical level (1 = pressed) to pad level
    function automatic logic pad(input logic logical);
`ifdef PB_ACTIVE_LOW_EN
        return ~logical;
`else
        return logical;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs compared as {level, press, release}
    task automatic test_reset();
        logic [2:0] got;
        logic [2:0] exp;
        rst    = 1'b1;
        pb_raw = pad(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {pb_level, pb_press, pb_release};
            total++;
            if (got !== 3'b000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=000", i, got);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            exp = {(i >= 9), (i == 9), 1'b0};
            got = {pb_level, pb_press, pb_release};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_requalify t0+%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [2:0] got;
        logic [2:0] exp;
        pb_raw = pad(1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = {(i < 9), 1'b0, (i == 9)};
            got = {pb_level, pb_press, pb_release};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL release t0+%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] got;
        logic [2:0] exp;
        pb_raw = pad(1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = {(i >= 9), (i == 9), 1'b0};
            got = {pb_level, pb_press, pb_release};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL clean_press t0+%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_release_reset();
        logic [2:0] got;
        logic [2:0] exp;
        pb_raw = pad(1'b0);
        for (int i = 0; i < 20; i++) begin
            rst = (i == 5);
            tick();
            exp = (i < 5) ? 3'b100 : 3'b000;
            got = {pb_level, pb_press, pb_release};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL release_reset t0+%0d got=%b exp=%b", i, got, exp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_bounce();
        logic [2:0] got;
        for (int i = 0; i < 42; i++) begin
            pb_raw = (i < 30) ? pad(((i / 3) % 2) == 0) : pad(1'b0);
            tick();
            got = {pb_level, pb_press, pb_release};
            total++;
            if (got !== 3'b000) begin
                bad++;
                $display("FAIL bounce cyc=%0d got=%b exp=000", i, got);
            end
        end
    endtask

    task automatic test_threshold();
        logic [2:0] got;
        logic [2:0] exp;
        for (int i = 0; i < 20; i++) begin
            pb_raw = pad(i < 7);
            tick();
            got = {pb_level, pb_press, pb_release};
            total++;
            if (got !== 3'b000) begin
                bad++;
                $display("FAIL threshold_7 t0+%0d got=%b exp=000", i, got);
            end
        end
        for (int i = 0; i < 26; i++) begin
            pb_raw = pad(i < 8);
            tick();
            exp = {(i >= 9 && i < 17), (i == 9), (i == 17)};
            got = {pb_level, pb_press, pb_release};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL threshold_8 t0+%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

`ifdef PB_ACTIVE_LOW_EN
    task automatic test_active_low();
        logic [2:0] got;
        logic [2:0] exp;
        pb_raw = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            got = {pb_level, pb_press, pb_release};
            total++;
            if (got !== 3'b000) begin
                bad++;
                $display("FAIL active_low_idle cyc=%0d got=%b exp=000", i, got);
            end
        end
        pb_raw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = {(i >= 9), (i == 9), 1'b0};
            got = {pb_level, pb_press, pb_release};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL active_low_press t0+%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        pb_raw = pad(1'b0);
        test_reset();
        test_release();
        test_clean_press();
        test_release_reset();
        test_bounce();
        test_threshold();
`ifdef PB_ACTIVE_LOW_EN
        test_active_low();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule : tb_pb_debounce
`default_nettype wire
